me_mem_stage: RTL and testbench
===============================

# me_mem_stage

Memory-stage controller and ME/WB pipeline register for the 5-stage MIPS pipeline. It consumes the `me_*` bundle from the EX/ME register and drives a single-ported data memory over a request/acknowledge handshake. It stalls upstream stages while an access is outstanding and presents the write-back bundle (`wb_*`) to the register file. It supports loads, stores and pass-through ALU results, with bubble insertion, misalignment detection and an access timeout.

## Interface

Parameters:

- `TIMEOUT`, 16: maximum number of ACCESS cycles without `dmem_ack` before the access is aborted (range 2..255).

Ports:

- `clk`: in, 1. Rising-edge clock.
- `rst`: in, 1. Synchronous, active-high reset.
- `me_aluresult`: in, 32. Effective address, or ALU result.
- `me_d2`: in, 32. Store data.
- `me_td`: in, 5. Destination register.
- `me_WREG`: in, 1. Register write enable.
- `me_WMEM`: in, 1. Store.
- `me_LW`: in, 1. Load.
- `me_instr`: in, 32. Instruction word, used for trace/debug.
- `dmem_req`: out, 1. Memory request.
- `dmem_we`: out, 1. 1 = write.
- `dmem_addr`: out, 32. Word-aligned address.
- `dmem_wdata`: out, 32. Store data.
- `dmem_ack`: in, 1. One-cycle completion pulse.
- `dmem_rdata`: in, 32. Load data; valid when `dmem_ack`=1.
- `stall`: out, 1. Freeze PC, IF/ID, ID/EX and EX/ME.
- `wb_data`: out, 32. Write-back value.
- `wb_td`: out, 5. Write-back destination.
- `wb_WREG`: out, 1. Write-back enable.
- `wb_instr`: out, 32. Instruction in WB.
- `mem_err`: out, 1. Sticky error flag: misaligned access or timeout.

## Operation

- Memory op: `memop` = `me_LW` | `me_WMEM`. `me_LW` and `me_WMEM` both high is illegal; the block treats it as a load.
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE, `memop`=0:
  - `stall`=0.
  - At the edge: `wb_data`←`me_aluresult`, `wb_td`←`me_td`, `wb_WREG`←`me_WREG`, `wb_instr`←`me_instr`.
- IDLE, `memop`=1, `me_aluresult[1:0]`≠0 (misaligned):
  - No request is issued. `stall`=0.
  - `mem_err`←1.
  - WB loads a bubble: `wb_WREG`=0, `wb_instr`=NOP (32'h0000_0020).
- IDLE, `memop`=1, aligned:
  - `stall`=1. WB loads a bubble.
  - Next state is ACCESS; the timeout counter clears to 0.
- ACCESS:
  - Outputs: `stall`=1, `dmem_req`=1, `dmem_we`=`me_WMEM`, `dmem_addr`=`{me_aluresult[31:2],2'b00}`, `dmem_wdata`=`me_d2`. These are combinational from the `me_*` inputs, which stay stable because of `stall`.
  - Each cycle, WB loads a bubble.
  - `dmem_ack`=1: `rdata_q`←`dmem_rdata`; next state DONE.
  - No ack and counter = `TIMEOUT`-1: `mem_err`←1; abort flag set; next state DONE.
  - Otherwise the counter increments.
- DONE:
  - `stall`=0, `dmem_req`=0.
  - At the edge, WB loads the real instruction:
    - `wb_data` = `rdata_q` for a load, `me_aluresult` for a store.
    - `wb_WREG` = `me_WREG` & ~abort.
  - Next state is IDLE.
- Outside ACCESS, `dmem_req`=0 and `dmem_ack` is ignored.
- `mem_err` clears only on `rst`.

## Timing

- Reset values: `wb_data`=0, `wb_td`=0, `wb_WREG`=0, `wb_instr`=32'h0000_0020, `mem_err`=0, `stall`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0.
- Non-memory instruction: 1-cycle latency; no stall.
- Memory op with ack in the k-th ACCESS cycle (k≥1):
  - `stall` is high for 1+k cycles.
  - The WB register updates at the end of the DONE cycle, which is k+2 edges after the op enters ME.
- Back-to-back memory ops: DONE returns to IDLE, so the next op costs one extra stall cycle. There is no overlap.
- Reset in ACCESS: next state IDLE. `dmem_req` is low from the cycle after the reset edge. A late ack is ignored.
- `dmem_ack` in the same cycle the timeout fires: the ack wins; no error is raised.

## Structure

- Shared package `mips_pkg`:
  - `NOP_INSTR` = 32'h0000_0020.
  - The `mem_state_t` enum {IDLE, ACCESS, DONE}.
- Sub-module `mem_timeout_cnt`: 8-bit counter with clear, enable and `hit` (count = `TIMEOUT`-1). It is instantiated once.
- FSM, WB register and output muxing are in `me_mem_stage`.

## Test plan

- ALU pass-through: `me_aluresult`=0x1234, `me_td`=5, `me_WREG`=1 → one edge later `wb_data`=0x1234, `wb_td`=5, `wb_WREG`=1; `stall` never asserted.
- Load, ack in the first ACCESS cycle, `dmem_rdata`=0xDEADBEEF, address 0x40:
  - `dmem_addr`=0x40 and `dmem_we`=0 in ACCESS; `stall` high for 2 cycles.
  - `wb_data`=0xDEADBEEF, `wb_WREG`=1 after DONE.
  - Two bubbles (`wb_instr`=0x20) precede the result.
- Store, ack after 3 cycles, address 0x80, `me_d2`=0x55AA:
  - `dmem_we`=1, `dmem_wdata`=0x55AA held for 3 cycles.
  - `stall` high for 4 cycles; `wb_WREG`=0.
- Timeout with `TIMEOUT`=4 and no ack on a load → after 4 ACCESS cycles `mem_err`=1, DONE, `wb_WREG`=0; `mem_err` stays 1.
- Misaligned load at 0x42 → no `dmem_req`, `mem_err`=1, bubble written, `stall`=0.
- `rst` asserted in the 2nd ACCESS cycle, then ack one cycle later → all outputs at reset values; the ack has no effect; the next ALU op passes through normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: NOP encoding and the memory-stage FSM states.
// Pure declarations, no logic.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access timeout counter: counts enabled cycles and flags when count reaches TIMEOUT-1.
// Registered count, combinational hit; clear has priority over enable.
module mem_timeout_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= 8'd0;
      end else if (en) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign hit = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/me_mem_stage.sv
// MEM stage controller + ME/WB register: non-memory ops pass in 1 cycle, memory ops take k+2 cycles.
// Stalls upstream for the IDLE issue cycle and every ACCESS cycle; aborts after TIMEOUT cycles without ack.
module me_mem_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] me_aluresult,
   input  logic [31:0] me_d2,
   input  logic [4:0]  me_td,
   input  logic        me_WREG,
   input  logic        me_WMEM,
   input  logic        me_LW,
   input  logic [31:0] me_instr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_td,
   output logic        wb_WREG,
   output logic [31:0] wb_instr,
   output logic        mem_err
);

   mem_state_t  state, next_state;
   logic        memop, misaligned;
   logic        cnt_clr, cnt_en, cnt_hit;
   logic        abort_q;
   logic [31:0] rdata_q;

   assign memop      = me_LW | me_WMEM;
   assign misaligned = (me_aluresult[1:0] != 2'b00);

   mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .hit (cnt_hit)
   );

   always_comb begin
      next_state = state;
      stall      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'd0;
      dmem_wdata = 32'd0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      unique case (state)
         IDLE: begin
            if (memop && !misaligned) begin
               stall      = 1'b1;
               cnt_clr    = 1'b1;
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            stall      = 1'b1;
            dmem_req   = 1'b1;
            // A simultaneous LW/WMEM is resolved as a load
            dmem_we    = me_WMEM & ~me_LW;
            dmem_addr  = {me_aluresult[31:2], 2'b00};
            dmem_wdata = me_d2;
            if (dmem_ack || cnt_hit) begin
               next_state = DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wb_data  <= 32'd0;
         wb_td    <= 5'd0;
         wb_WREG  <= 1'b0;
         wb_instr <= NOP_INSTR;
         mem_err  <= 1'b0;
         abort_q  <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state <= next_state;
         unique case (state)
            IDLE: begin
               if (!memop) begin
                  wb_data  <= me_aluresult;
                  wb_td    <= me_td;
                  wb_WREG  <= me_WREG;
                  wb_instr <= me_instr;
               end else begin
                  wb_WREG  <= 1'b0;
                  wb_instr <= NOP_INSTR;
                  if (misaligned) begin
                     mem_err <= 1'b1;
                  end else begin
                     abort_q <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               wb_WREG  <= 1'b0;
               wb_instr <= NOP_INSTR;
               // Ack wins over a timeout firing in the same cycle
               if (dmem_ack) begin
                  rdata_q <= dmem_rdata;
               end else if (cnt_hit) begin
                  mem_err <= 1'b1;
                  abort_q <= 1'b1;
               end
            end
            DONE: begin
               wb_data  <= me_LW ? rdata_q : me_aluresult;
               wb_td    <= me_td;
               wb_WREG  <= me_WREG & ~abort_q;
               wb_instr <= me_instr;
            end
            default: begin
               wb_WREG <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_me_mem_stage.sv
// Directed bench for me_mem_stage with a cycle-level expectation model and per-cycle compare.
module tb_me_mem_stage;

   localparam int          T   = 4;
   localparam logic [31:0] NOP = 32'h0000_0020;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] me_aluresult, me_d2, me_instr;
   logic [4:0]  me_td;
   logic        me_WREG, me_WMEM, me_LW;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        stall;
   logic [31:0] wb_data, wb_instr;
   logic [4:0]  wb_td;
   logic        wb_WREG, mem_err;

   always #5 clk = ~clk;

   me_mem_stage #(.TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .me_aluresult(me_aluresult), .me_d2(me_d2), .me_td(me_td),
      .me_WREG(me_WREG), .me_WMEM(me_WMEM), .me_LW(me_LW), .me_instr(me_instr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .wb_data(wb_data), .wb_td(wb_td), .wb_WREG(wb_WREG),
      .wb_instr(wb_instr), .mem_err(mem_err)
   );

   int n_chk = 0;
   int n_fail = 0;
   int stall_cnt = 0;
   bit chk_en = 1'b0;

   // Expected outputs for the current cycle
   logic        e_stall, e_req, e_we, e_wb_WREG, e_err;
   logic [31:0] e_addr, e_wdata, e_wb_data, e_wb_instr;
   logic [4:0]  e_wb_td;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (stall === 1'b1) stall_cnt++;
         chk("stall",      {31'd0, stall},    {31'd0, e_stall});
         chk("dmem_req",   {31'd0, dmem_req}, {31'd0, e_req});
         chk("dmem_we",    {31'd0, dmem_we},  {31'd0, e_we});
         chk("dmem_addr",  dmem_addr,         e_addr);
         chk("dmem_wdata", dmem_wdata,        e_wdata);
         chk("wb_data",    wb_data,           e_wb_data);
         chk("wb_td",      {27'd0, wb_td},    {27'd0, e_wb_td});
         chk("wb_WREG",    {31'd0, wb_WREG},  {31'd0, e_wb_WREG});
         chk("wb_instr",   wb_instr,          e_wb_instr);
         chk("mem_err",    {31'd0, mem_err},  {31'd0, e_err});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic no_mem_exp(input logic s);
      e_stall = s;
      e_req   = 1'b0;
      e_we    = 1'b0;
      e_addr  = 32'd0;
      e_wdata = 32'd0;
   endtask

   task automatic bubble_exp();
      e_wb_WREG  = 1'b0;
      e_wb_instr = NOP;
   endtask

   task automatic zero_inputs();
      me_aluresult = 32'd0; me_d2 = 32'd0; me_td = 5'd0; me_instr = 32'd0;
      me_WREG = 1'b0; me_WMEM = 1'b0; me_LW = 1'b0;
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
   endtask

   task automatic reset_exp();
      no_mem_exp(1'b0);
      e_wb_data = 32'd0; e_wb_td = 5'd0; e_wb_WREG = 1'b0; e_wb_instr = NOP; e_err = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      zero_inputs();
      step();
      rst = 1'b0;
      reset_exp();
   endtask

   // One instruction through ME; ack_at = ACCESS cycle of the ack, 0 = never
   task automatic run_op(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] d2, input logic [4:0] td, input logic wreg,
                         input logic [31:0] instr, input int ack_at,
                         input logic [31:0] rdata, input logic ack_in_done);
      logic ab;
      logic fin;
      me_LW = ld; me_WMEM = st; me_aluresult = addr; me_d2 = d2;
      me_td = td; me_WREG = wreg; me_instr = instr;
      dmem_ack = 1'b0;
      if (!(ld | st)) begin
         no_mem_exp(1'b0);
         step();
         e_wb_data = addr; e_wb_td = td; e_wb_WREG = wreg; e_wb_instr = instr;
      end else if (addr[1:0] != 2'b00) begin
         no_mem_exp(1'b0);
         step();
         bubble_exp();
         e_err = 1'b1;
      end else begin
         no_mem_exp(1'b1);
         step();
         bubble_exp();
         ab  = 1'b0;
         fin = 1'b0;
         for (int n = 1; n <= T && !fin; n++) begin
            e_stall = 1'b1; e_req = 1'b1; e_we = st & ~ld;
            e_addr = addr & 32'hFFFF_FFFC; e_wdata = d2;
            dmem_ack   = (n == ack_at);
            dmem_rdata = (n == ack_at) ? rdata : 32'hFFFF_0000;
            step();
            dmem_ack = 1'b0;
            bubble_exp();
            if (n == ack_at) fin = 1'b1;
            else if (n == T) begin
               fin = 1'b1; ab = 1'b1; e_err = 1'b1;
            end
         end
         no_mem_exp(1'b0);
         dmem_ack   = ack_in_done;
         dmem_rdata = 32'hBAD0_BAD0;
         step();
         dmem_ack = 1'b0;
         e_wb_data = ld ? rdata : addr; e_wb_td = td;
         e_wb_WREG = wreg & ~ab; e_wb_instr = instr;
      end
   endtask

   initial begin
      rst = 1'b1;
      zero_inputs();
      reset_exp();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // ALU pass-through
      stall_cnt = 0;
      run_op(0, 0, 32'h1234, 32'h0, 5'd5, 1, 32'h0085_1020, 0, 32'h0, 0);
      chk("alu_wb_data", wb_data, 32'h0000_1234);
      chk("alu_wb_td", {27'd0, wb_td}, 32'd5);
      chk("alu_no_stall", stall_cnt, 32'd0);

      // Load, ack in first ACCESS cycle; stray ack in DONE must be ignored
      stall_cnt = 0;
      run_op(1, 0, 32'h40, 32'h0, 5'd8, 1, 32'h8C08_0040, 1, 32'hDEAD_BEEF, 1);
      chk("ld_stall_cycles", stall_cnt, 32'd2);
      chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
      chk("ld_wb_WREG", {31'd0, wb_WREG}, 32'd1);

      // Store, ack after 3 cycles
      stall_cnt = 0;
      run_op(0, 1, 32'h80, 32'h55AA, 5'd0, 0, 32'hAC09_0080, 3, 32'h0, 0);
      chk("st_stall_cycles", stall_cnt, 32'd4);
      chk("st_wb_WREG", {31'd0, wb_WREG}, 32'd0);

      // Back-to-back loads, illegal LW+WMEM handled as load, ack coinciding with timeout
      run_op(1, 0, 32'h1000, 32'h0, 5'd9, 1, 32'h8C09_1000, 2, 32'h0BAD_F00D, 0);
      run_op(1, 1, 32'h2004, 32'h77, 5'd10, 1, 32'hFC0A_2004, 2, 32'h1357_9BDF, 0);
      run_op(1, 0, 32'h3008, 32'h0, 5'd11, 1, 32'h8C0B_3008, T, 32'hCAFE_0001, 0);
      chk("ack_at_timeout_no_err", {31'd0, mem_err}, 32'd0);
      chk("ack_at_timeout_data", wb_data, 32'hCAFE_0001);

      // Reset in the second ACCESS cycle, then a late ack
      me_LW = 1'b1; me_WMEM = 1'b0; me_aluresult = 32'h100; me_d2 = 32'h0;
      me_td = 5'd3; me_WREG = 1'b1; me_instr = 32'h8C03_0100; dmem_ack = 1'b0;
      no_mem_exp(1'b1);
      step();
      bubble_exp();
      e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h100; e_wdata = 32'h0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      zero_inputs();
      dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
      reset_exp();
      step();
      dmem_ack = 1'b0;
      e_wb_instr = 32'd0;
      chk("rst_late_ack_no_err", {31'd0, mem_err}, 32'd0);
      run_op(0, 0, 32'hABCD, 32'h0, 5'd7, 1, 32'h0000_0820, 0, 32'h0, 0);
      chk("post_rst_alu", wb_data, 32'h0000_ABCD);

      // Misaligned load
      stall_cnt = 0;
      run_op(1, 0, 32'h42, 32'h0, 5'd4, 1, 32'h8C04_0042, 0, 32'h0, 0);
      chk("misal_err", {31'd0, mem_err}, 32'd1);
      chk("misal_instr", wb_instr, 32'h0000_0020);
      chk("misal_no_stall", stall_cnt, 32'd0);

      // Timeout on a load after a fresh reset; error stays sticky
      do_reset();
      run_op(1, 0, 32'h44, 32'h0, 5'd6, 1, 32'h8C06_0044, 0, 32'h0, 0);
      chk("to_err", {31'd0, mem_err}, 32'd1);
      chk("to_wb_WREG", {31'd0, wb_WREG}, 32'd0);
      run_op(0, 0, 32'h55, 32'h0, 5'd2, 1, 32'h0000_1020, 0, 32'h0, 0);
      chk("to_err_sticky", {31'd0, mem_err}, 32'd1);

      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
